modbus_tx_framer: RTL and testbench
===================================

# modbus_tx_framer

Response frame builder that sits directly downstream of the Modbus function handler. When the handler pulses `handler_done`, the block does three things: it latches the response descriptor, reads register words from the dual-port RAM the handler filled, and serialises the complete Modbus RTU response to the UART transmitter one byte at a time. It appends a CRC-16 that it computes itself.

## Interface

- No parameters.

Ports (name, direction, width, meaning):

- `clk` — in — 1 — system clock.
- `rst_n` — in — 1 — reset, synchronous, active-low.
- `dev_addr` — in — 8 — slave address; first byte of every frame.
- `handler_done` — in — 1 — one-cycle pulse; descriptor inputs are valid in the same cycle.
- `exception_in` — in — 8 — exception code; 0 means normal response.
- `func_code` — in — 8 — request function code.
- `addr` — in — 16 — request register address (echoed for 0x06).
- `data` — in — 16 — request data (echoed for 0x06).
- `tx_quantity` — in — 8 — number of register words held in the DPRAM for 0x03/0x04.
- `dpram_raddr` — out — 8 — DPRAM read address; read latency is 1 cycle.
- `dpram_rdata` — in — 16 — DPRAM read data.
- `tx_byte` — out — 8 — byte offered to the UART transmitter.
- `tx_valid` — out — 1 — `tx_byte` is valid.
- `tx_ready` — in — 1 — UART accepts a byte when `tx_valid && tx_ready`.
- `busy` — out — 1 — high from the latch cycle through the `frame_done` cycle.
- `frame_done` — out — 1 — one-cycle pulse after the last CRC byte is accepted.

## Operation

- Latch on `handler_done` in IDLE: `dev_addr`, `exception_in`, `func_code`, `addr`, `data`, and quantity. Quantity is clamped to 125 when `tx_quantity > 125`.
- `handler_done` while `busy`: ignored and dropped.
- Frame selection and byte order:
  - Exception (code ≠ 0): dev_addr, func_code|0x80, code, CRC lo, CRC hi. 5 bytes.
  - 0x03/0x04, normal: dev_addr, func_code, byte count (2·N), then for words k = 0..N−1: DPRAM[k] hi, DPRAM[k] lo; then CRC lo, CRC hi. 5+2N bytes.
  - 0x06, normal: dev_addr, 0x06, addr hi, addr lo, data hi, data lo, CRC lo, CRC hi. 8 bytes.
  - Any other code with exception 0: no frame, no `frame_done`, return to IDLE.
  - N = 0 on 0x03/0x04: byte count 0x00, no DPRAM reads, 5 bytes.
- CRC: Modbus CRC-16, reflected polynomial 0xA001, initial value 0xFFFF.
  - Updated byte-wise on each accepted non-CRC byte.
  - Reinitialised at each latch.
  - Low byte is sent first.
- State machine:
  - IDLE → HDR on a latch.
  - HDR sends the header bytes: 3 bytes for 0x03/0x04, otherwise all payload bytes.
  - HDR → FETCH if N > 0, else → CRC_LO.
  - FETCH: `dpram_raddr` = k; `tx_valid` low for 1 cycle.
  - REG_HI: sends `dpram_rdata[15:8]`.
  - REG_LO: sends `dpram_rdata[7:0]`; then → FETCH (k+1) or → CRC_LO after the last word.
  - CRC_LO → CRC_HI → DONE (`frame_done` = 1, `busy` = 1) → IDLE.
- `dpram_raddr` holds its value from FETCH until the next FETCH, so `dpram_rdata` stays stable during REG_HI/REG_LO stalls.
- Handshake:
  - `tx_byte` stays stable and `tx_valid` stays high until the byte is accepted.
  - A state advances only on acceptance.
  - `tx_valid` is low in IDLE, FETCH and DONE.
- Reset values: `tx_valid` 0, `tx_byte` 0x00, `dpram_raddr` 0x00, `busy` 0, `frame_done` 0, CRC 0xFFFF, state IDLE.
- Reset mid-frame: at the next clock edge with `rst_n` = 0, the frame is aborted. Outputs go to reset values and no `frame_done` is issued.

## Timing

- `handler_done` at cycle T: `busy` = 1 from T+1, and the first `tx_valid` (dev_addr) is at T+1.
- With `tx_ready` held high, `frame_done` occurs at:
  - exception: T+6;
  - 0x06: T+9;
  - 0x03/0x04: T+6+3N (each word costs FETCH + 2 bytes).
- `busy` falls in the cycle after `frame_done`. A new `handler_done` is accepted in that cycle or later.
- Each cycle `tx_ready` is low inserts exactly one stall cycle; no byte is dropped or duplicated.

## Test plan

- Exception: dev 0x01, func 0x03, code 0x02, `tx_ready` = 1 → bytes 01 83 02 C0 F1; `frame_done` at T+6.
- Write echo: dev 0x01, func 0x06, addr 0x0001, data 0x0003 → bytes 01 06 00 01 00 03 98 0B; `frame_done` at T+9.
- Read 0x03: N = 1, DPRAM[0] = 0x0001 → bytes 01 03 02 00 01 79 84. `dpram_raddr` = 0 in the FETCH cycle T+4.
- Read 0x04: N = 4, DPRAM = 0x1111/0x2222/0x3333/0x4444, `tx_ready` toggled 1/0 every cycle → bytes 01 04 08 11 11 22 22 33 33 44 44 plus CRC matching the software model. `tx_byte` is stable across stalls, and 13 bytes total are sent.
- Second `handler_done` during a busy frame → ignored; only the first frame appears on the output.
- `rst_n` low for 1 cycle after the 3rd byte of a 0x06 frame → `tx_valid` = 0 at the next edge, no `frame_done`. A following exception frame is correct, which shows the CRC restarted at 0xFFFF.

Source files
------------

// File: rtl/modbus_tx_framer.sv
// modbus_tx_framer
// Builds a Modbus RTU response frame after the function handler finishes.
// The descriptor is latched, register words are read from the handler's
// DPRAM, and the frame is streamed one byte at a time to the UART
// transmitter. A CRC-16 (reflected polynomial 0xA001) is appended.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   dev_addr                    slave address, first byte of every frame
//   handler_done                one-cycle start pulse, descriptor valid with it
//   exception_in                exception code, 0 = normal response
//   func_code, addr, data       request descriptor
//   tx_quantity                 register words in DPRAM for 0x03/0x04
//   dpram_raddr / dpram_rdata   DPRAM read port, 1-cycle read latency
//   tx_byte, tx_valid, tx_ready byte stream to the UART (valid/ready)
//   busy                        frame in progress (latch through done)
//   frame_done                  one-cycle pulse after the last CRC byte
module modbus_tx_framer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  dev_addr,
  input  logic        handler_done,
  input  logic [7:0]  exception_in,
  input  logic [7:0]  func_code,
  input  logic [15:0] addr,
  input  logic [15:0] data,
  input  logic [7:0]  tx_quantity,
  output logic [7:0]  dpram_raddr,
  input  logic [15:0] dpram_rdata,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    FETCH  = 3'd2,
    REG_HI = 3'd3,
    REG_LO = 3'd4,
    CRC_LO = 3'd5,
    CRC_HI = 3'd6,
    DONE   = 3'd7
  } state_t;

  // One byte step of the Modbus CRC-16.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  b);
    logic [15:0] c;
    c = crc_in ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ 16'hA001;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  // Header/payload byte at position idx of the non-register part of a frame.
  function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                          input logic [7:0]  dv,
                                          input logic [7:0]  fc,
                                          input logic [7:0]  ex,
                                          input logic [15:0] ad,
                                          input logic [15:0] dt,
                                          input logic [6:0]  qt,
                                          input logic        rd);
    logic [7:0] r;
    case (idx)
      3'd0:    r = dv;
      3'd1:    r = (ex != 8'h00) ? (fc | 8'h80) : fc;
      3'd2:    r = (ex != 8'h00) ? ex : (rd ? {qt, 1'b0} : ad[15:8]);
      3'd3:    r = ad[7:0];
      3'd4:    r = dt[15:8];
      3'd5:    r = dt[7:0];
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  state_t      state_r, state_d;
  logic [7:0]  dev_r, func_r, exc_r;
  logic [15:0] addr_r, data_r;
  logic [6:0]  qty_r;
  logic        is_read_r;
  logic [2:0]  idx_r, idx_d;
  logic [6:0]  word_r, word_d;
  logic [15:0] crc_r, crc_d;
  logic [7:0]  byte_r, byte_d;
  logic [7:0]  raddr_r, raddr_d;
  logic        valid_r, valid_d;
  logic        busy_r, busy_d;
  logic        done_r, done_d;

  logic        latch_s;
  logic        accept_s;
  logic        frame_ok_s;
  logic        in_read_s;
  logic [2:0]  hdr_last_s;
  logic [15:0] crc_acc_s;

  // Register bytes come straight from the DPRAM; the held read address keeps them stable.
  assign tx_byte     = (state_r == REG_HI) ? dpram_rdata[15:8] :
                       (state_r == REG_LO) ? dpram_rdata[7:0]  : byte_r;
  assign tx_valid    = valid_r;
  assign busy        = busy_r;
  assign frame_done  = done_r;
  assign dpram_raddr = raddr_r;

  assign accept_s   = valid_r && tx_ready;
  assign in_read_s  = (func_code == 8'h03) || (func_code == 8'h04);
  assign frame_ok_s = (exception_in != 8'h00) || in_read_s || (func_code == 8'h06);
  assign hdr_last_s = ((exc_r != 8'h00) || is_read_r) ? 3'd2 : 3'd5;
  assign crc_acc_s  = crc16_byte(crc_r, tx_byte);

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_r;
    idx_d   = idx_r;
    word_d  = word_r;
    crc_d   = crc_r;
    byte_d  = byte_r;
    raddr_d = raddr_r;
    latch_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (handler_done && frame_ok_s) begin
          latch_s = 1'b1;
          state_d = HDR;
          idx_d   = 3'd0;
          word_d  = 7'd0;
          crc_d   = 16'hFFFF;
          byte_d  = dev_addr;
        end else begin
          state_d = IDLE;
        end
      end
      HDR: begin
        if (accept_s) begin
          crc_d = crc_acc_s;
          if (idx_r == hdr_last_s) begin
            if (is_read_r && (qty_r != 7'd0)) begin
              state_d = FETCH;
              raddr_d = 8'd0;
            end else begin
              state_d = CRC_LO;
              byte_d  = crc_acc_s[7:0];
            end
          end else begin
            idx_d  = idx_r + 3'd1;
            byte_d = hdr_byte(idx_r + 3'd1, dev_r, func_r, exc_r, addr_r, data_r,
                              qty_r, is_read_r);
          end
        end else begin
          state_d = HDR;
        end
      end
      FETCH: begin
        state_d = REG_HI;
      end
      REG_HI: begin
        if (accept_s) begin
          crc_d   = crc_acc_s;
          state_d = REG_LO;
        end else begin
          state_d = REG_HI;
        end
      end
      REG_LO: begin
        if (accept_s) begin
          crc_d = crc_acc_s;
          if (word_r == (qty_r - 7'd1)) begin
            state_d = CRC_LO;
            byte_d  = crc_acc_s[7:0];
          end else begin
            word_d  = word_r + 7'd1;
            raddr_d = {1'b0, word_r + 7'd1};
            state_d = FETCH;
          end
        end else begin
          state_d = REG_LO;
        end
      end
      CRC_LO: begin
        if (accept_s) begin
          state_d = CRC_HI;
          byte_d  = crc_r[15:8];
        end else begin
          state_d = CRC_LO;
        end
      end
      CRC_HI: begin
        if (accept_s) begin
          state_d = DONE;
        end else begin
          state_d = CRC_HI;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    valid_d = (state_d == HDR) || (state_d == REG_HI) || (state_d == REG_LO) ||
              (state_d == CRC_LO) || (state_d == CRC_HI);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  // State, descriptor and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      dev_r     <= 8'h00;
      func_r    <= 8'h00;
      exc_r     <= 8'h00;
      addr_r    <= 16'h0000;
      data_r    <= 16'h0000;
      qty_r     <= 7'd0;
      is_read_r <= 1'b0;
      idx_r     <= 3'd0;
      word_r    <= 7'd0;
      crc_r     <= 16'hFFFF;
      byte_r    <= 8'h00;
      raddr_r   <= 8'h00;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r <= state_d;
      idx_r   <= idx_d;
      word_r  <= word_d;
      crc_r   <= crc_d;
      byte_r  <= byte_d;
      raddr_r <= raddr_d;
      valid_r <= valid_d;
      busy_r  <= busy_d;
      done_r  <= done_d;
      if (latch_s) begin
        dev_r     <= dev_addr;
        func_r    <= func_code;
        exc_r     <= exception_in;
        addr_r    <= addr;
        data_r    <= data;
        // Largest legal read response is 125 words.
        qty_r     <= (tx_quantity > 8'd125) ? 7'd125 : tx_quantity[6:0];
        is_read_r <= (exception_in == 8'h00) && in_read_s;
      end
    end
  end

endmodule

// File: tb/tb_modbus_tx_framer.sv
// Scoreboard bench for modbus_tx_framer: stimulus pushes expected bytes and
// frame_done cycles into queues; a negedge monitor pops and compares.
module tb_modbus_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  dev_addr = 8'h00;
  logic        handler_done = 1'b0;
  logic [7:0]  exception_in = 8'h00;
  logic [7:0]  func_code = 8'h00;
  logic [15:0] addr = 16'h0000;
  logic [15:0] data = 16'h0000;
  logic [7:0]  tx_quantity = 8'h00;
  logic [7:0]  dpram_raddr;
  logic [15:0] dpram_rdata = 16'h0000;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        frame_done;

  modbus_tx_framer dut (
    .clk(clk), .rst_n(rst_n), .dev_addr(dev_addr), .handler_done(handler_done),
    .exception_in(exception_in), .func_code(func_code), .addr(addr), .data(data),
    .tx_quantity(tx_quantity), .dpram_raddr(dpram_raddr), .dpram_rdata(dpram_rdata),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .frame_done(frame_done)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DPRAM model with one cycle read latency.
  logic [15:0] mem [0:255];
  always @(posedge clk) dpram_rdata <= mem[dpram_raddr];

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  int         done_q[$];
  logic [7:0] frm[$];
  int         ready_mode = 0;

  task automatic chk(input string nm, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in ^ {8'h00, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return c;
  endfunction

  task automatic add_crc();
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (frm[i]) c = crc_upd(c, frm[i]);
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
  endtask

  task automatic commit();
    foreach (frm[i]) exp_q.push_back(frm[i]);
    frm.delete();
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] dv, input logic [7:0] fc, input logic [7:0] ex,
                       input logic [15:0] a, input logic [15:0] d, input logic [7:0] q);
    dev_addr = dv; func_code = fc; exception_in = ex; addr = a; data = d;
    tx_quantity = q; handler_done = 1'b1;
    step(1);
    handler_done = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && done_q.size() == 0) break;
      step(1);
    end
    chk("drain_timeout", exp_q.size() + done_q.size(), 0);
    exp_q.delete();
    done_q.delete();
    step(3);
  endtask

  // tx_ready generator: 0 = always ready, 1 = toggle each cycle, other = never.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Monitor: consumes accepted bytes and frame_done pulses.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  logic       prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        chk("stall_valid", tx_valid, 1);
        chk("stall_byte", tx_byte, prev_byte);
      end
      if (prev_done) chk("busy_after_done", busy, 0);
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) chk("spare_byte", exp_q.size(), 1);
        else chk("tx_byte", tx_byte, exp_q.pop_front());
      end
      if (frame_done) begin
        chk("done_expected", int'(done_q.size() > 0), 1);
        if (done_q.size() > 0) begin
          if (done_q[0] >= 0) chk("done_cycle", cyc, done_q[0]);
          void'(done_q.pop_front());
          chk("done_all_bytes", exp_q.size(), 0);
        end
      end
      prev_stall <= tx_valid && !tx_ready;
      prev_byte  <= tx_byte;
      prev_done  <= frame_done;
    end else begin
      prev_stall <= 1'b0;
      prev_done  <= 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 16'(k * 16'h0101) ^ 16'h5A3C;
    step(3);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_raddr", dpram_raddr, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    step(2);

    // Exception frame.
    frm = '{8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1};
    commit();
    done_q.push_back(cyc + 6);
    start(8'h01, 8'h03, 8'h02, 16'h0000, 16'h0000, 8'h00);
    chk("t1_busy", busy, 1);
    chk("t1_valid", tx_valid, 1);
    chk("t1_byte", tx_byte, 8'h01);
    wait_idle();

    // Write echo.
    frm = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
    commit();
    done_q.push_back(cyc + 9);
    start(8'h01, 8'h06, 8'h00, 16'h0001, 16'h0003, 8'h00);
    wait_idle();

    // Read 0x03, one word.
    mem[0] = 16'h0001;
    frm = '{8'h01, 8'h03, 8'h02, 8'h00, 8'h01, 8'h79, 8'h84};
    commit();
    done_q.push_back(cyc + 9);
    start(8'h01, 8'h03, 8'h00, 16'h0000, 16'h0000, 8'h01);
    step(3);
    chk("fetch_raddr", dpram_raddr, 8'h00);
    chk("fetch_valid", tx_valid, 0);
    wait_idle();

    // Read 0x04, four words, tx_ready toggling.
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    frm = '{8'h01, 8'h04, 8'h08, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};
    add_crc();
    chk("frame_len_13", frm.size(), 13);
    commit();
    done_q.push_back(-1);
    ready_mode = 1;
    start(8'h01, 8'h04, 8'h00, 16'h0000, 16'h0000, 8'h04);
    wait_idle();
    ready_mode = 0;
    step(2);

    // Zero-quantity read.
    frm = '{8'h11, 8'h03, 8'h00};
    add_crc();
    commit();
    done_q.push_back(cyc + 6);
    start(8'h11, 8'h03, 8'h00, 16'h0000, 16'h0000, 8'h00);
    wait_idle();

    // Quantity clamped to 125 words.
    for (int k = 0; k < 256; k++) mem[k] = 16'(k * 16'h0101) ^ 16'h5A3C;
    frm = '{8'h22, 8'h04, 8'hFA};
    for (int k = 0; k < 125; k++) begin
      frm.push_back(mem[k][15:8]);
      frm.push_back(mem[k][7:0]);
    end
    add_crc();
    commit();
    done_q.push_back(cyc + 6 + 3 * 125);
    start(8'h22, 8'h04, 8'h00, 16'h0000, 16'h0000, 8'd200);
    wait_idle();

    // Second handler_done while busy is dropped.
    frm = '{8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1};
    commit();
    done_q.push_back(cyc + 6);
    start(8'h01, 8'h03, 8'h02, 16'h0000, 16'h0000, 8'h00);
    step(2);
    start(8'h05, 8'h06, 8'h00, 16'h1234, 16'h5678, 8'h00);
    wait_idle();
    step(15);
    chk("ignored_busy", busy, 0);

    // Unsupported function code: no frame.
    start(8'h01, 8'h10, 8'h00, 16'h0000, 16'h0000, 8'h00);
    chk("unsup_busy_now", busy, 0);
    step(10);
    chk("unsup_busy_later", busy, 0);

    // Reset after the third byte of a write echo.
    frm = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
    commit();
    done_q.push_back(cyc + 9);
    start(8'h01, 8'h06, 8'h00, 16'h0001, 16'h0003, 8'h00);
    step(3);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("abort_valid", tx_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_left", exp_q.size(), 5);
    exp_q.delete();
    done_q.delete();
    step(12);
    frm = '{8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1};
    commit();
    done_q.push_back(cyc + 6);
    start(8'h01, 8'h03, 8'h02, 16'h0000, 16'h0000, 8'h00);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
